// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the data-memory master.
// Provides bus field widths, fixed burst/size encodings, response codes
// and the state type used by dm_axi_master's transaction FSM.
package axi_pkg;

    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        DM_IDLE,
        DM_AR,
        DM_R,
        DM_AW,
        DM_B
    } dm_state_e;

endpackage

// File: rtl/dm_axi_master.sv
// dm_axi_master: turns single-word CPU data-memory requests into single-beat
// AXI4 read/write transactions and stalls the pipeline until each completes.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cpu_read/cpu_write       level requests, held stable while cpu_stall=1
//   cpu_addr/wdata/wstrb     request payload
//   cpu_rdata                load data (bypassed from RDATA in the handshake cycle)
//   cpu_stall                data-side pipeline stall
//   bus_err                  sticky flag, set on any non-OKAY RRESP/BRESP
//   AR*/R*/AW*/W*/B*         AXI4 master channels (one beat, LEN=0, SIZE=4B, INCR)
module dm_axi_master
    import axi_pkg::*;
#(
    parameter int unsigned     ID_W      = AXI_ID_W,
    parameter logic [ID_W-1:0] MASTER_ID = ID_W'(1)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [AXI_ADDR_W-1:0] cpu_addr,
    input  logic [AXI_DATA_W-1:0] cpu_wdata,
    input  logic [AXI_STRB_W-1:0] cpu_wstrb,
    output logic [AXI_DATA_W-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  bus_err,

    output logic [ID_W-1:0]       ARID,
    output logic [AXI_ADDR_W-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,

    input  logic [ID_W-1:0]       RID,
    input  logic [AXI_DATA_W-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY,

    output logic [ID_W-1:0]       AWID,
    output logic [AXI_ADDR_W-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,

    output logic [AXI_DATA_W-1:0] WDATA,
    output logic [AXI_STRB_W-1:0] WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,

    input  logic [ID_W-1:0]       BID,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
);

    dm_state_e             state_q, state_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [AXI_DATA_W-1:0] wdata_q, wdata_d;
    logic [AXI_STRB_W-1:0] wstrb_q, wstrb_d;
    logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
    logic                  bus_err_q, bus_err_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;

    // Only one transaction is ever outstanding, so IDs and RLAST carry no information.
    logic unused_inputs;
    assign unused_inputs = ^{RID, BID, RLAST};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DM_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // A channel is finished once its handshake happened earlier or happens now.
    logic aw_fin, w_fin;
    assign aw_fin = aw_done_q | AWREADY;
    assign w_fin  = w_done_q  | WREADY;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        bus_err_d = bus_err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cpu_stall = 1'b0;

        unique case (state_q)
            DM_IDLE: begin
                cpu_stall = cpu_read | cpu_write;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (cpu_read || cpu_write) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    wstrb_d = cpu_wstrb;
                end
                // Write has priority; a simultaneous read is dropped.
                if (cpu_write) begin
                    state_d = DM_AW;
                end else if (cpu_read) begin
                    state_d = DM_AR;
                end
            end
            DM_AR: begin
                cpu_stall = 1'b1;
                if (ARREADY) begin
                    state_d = DM_R;
                end
            end
            DM_R: begin
                cpu_stall = !RVALID;
                if (RVALID) begin
                    rdata_d = RDATA;
                    if (RRESP != RESP_OKAY) begin
                        bus_err_d = 1'b1;
                    end
                    state_d = DM_IDLE;
                end
            end
            DM_AW: begin
                cpu_stall = 1'b1;
                if (aw_fin && w_fin) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = DM_B;
                end else begin
                    aw_done_d = aw_fin;
                    w_done_d  = w_fin;
                end
            end
            DM_B: begin
                cpu_stall = !BVALID;
                if (BVALID) begin
                    if (BRESP != RESP_OKAY) begin
                        bus_err_d = 1'b1;
                    end
                    state_d = DM_IDLE;
                end
            end
            default: begin
                state_d = DM_IDLE;
            end
        endcase
    end

    // VALIDs decode straight from state so an asynchronous reset drops them at once.
    assign ARVALID = (state_q == DM_AR);
    assign RREADY  = (state_q == DM_R);
    assign AWVALID = (state_q == DM_AW) && !aw_done_q;
    assign WVALID  = (state_q == DM_AW) && !w_done_q;
    assign WLAST   = WVALID;
    assign BREADY  = (state_q == DM_B);

    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = LEN_SINGLE;
    assign ARSIZE  = SIZE_4B;
    assign ARBURST = BURST_INCR;

    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = LEN_SINGLE;
    assign AWSIZE  = SIZE_4B;
    assign AWBURST = BURST_INCR;

    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;

    // Bypass lets the load data be valid on the edge where the stall drops.
    assign cpu_rdata = (state_q == DM_R && RVALID) ? RDATA : rdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dm_axi_master.sv
// Directed self-checking bench for dm_axi_master. The slave side is driven
// cycle by cycle from hand-written schedules; every expected value below is
// derived by hand from the FSM's intended cycle behaviour.
module tb_dm_axi_master;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic        cpu_stall, bus_err;
    logic [3:0]  ARID, RID, AWID, BID;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
    logic [7:0]  ARLEN, AWLEN;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [3:0]  WSTRB;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    dm_axi_master #(.ID_W(4), .MASTER_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .bus_err(bus_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks sample 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
        RVALID = 1'b0; RDATA = '0; RRESP = RESP_OKAY; RLAST = 1'b0; RID = 4'd1;
        BVALID = 1'b0; BRESP = RESP_OKAY; BID = 4'd1;
    endtask

    initial begin
        rst = 1'b0;
        cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        slave_idle();

        // ---------------- reset state ----------------
        tick(); tick();
        #2;
        check("rst_arvalid", 32'(ARVALID), 32'd0);
        check("rst_awvalid", 32'(AWVALID), 32'd0);
        check("rst_wvalid",  32'(WVALID),  32'd0);
        check("rst_rready",  32'(RREADY),  32'd0);
        check("rst_bready",  32'(BREADY),  32'd0);
        check("rst_rdata",   cpu_rdata,    32'd0);
        check("rst_buserr",  32'(bus_err), 32'd0);
        check("rst_stall0",  32'(cpu_stall), 32'd0);
        cpu_read = 1'b1;
        #1;
        check("rst_stall_req", 32'(cpu_stall), 32'd1);
        cpu_read = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // ---------------- T1: read, ARREADY +2 waits, RVALID +3 waits ----------------
        for (int c = 0; c < 8; c++) begin
            cpu_read = 1'b1;
            cpu_addr = 32'h0001_0004;
            ARREADY  = (c == 3);
            RVALID   = (c == 7);
            RDATA    = 32'hDEAD_BEEF;
            #2;
            check($sformatf("t1_stall_c%0d", c),   32'(cpu_stall), 32'(c < 7));
            check($sformatf("t1_arvalid_c%0d", c), 32'(ARVALID),   32'(c >= 1 && c <= 3));
            check($sformatf("t1_rready_c%0d", c),  32'(RREADY),    32'(c >= 4));
            check($sformatf("t1_rdata_c%0d", c),   cpu_rdata,      (c == 7) ? 32'hDEAD_BEEF : 32'd0);
            if (c == 1) begin
                check("t1_araddr",  ARADDR,        32'h0001_0004);
                check("t1_arid",    32'(ARID),     32'd1);
                check("t1_arlen",   32'(ARLEN),    32'd0);
                check("t1_arsize",  32'(ARSIZE),   32'd2);
                check("t1_arburst", 32'(ARBURST),  32'd1);
            end
            tick();
        end
        cpu_read = 1'b0;
        slave_idle();
        #2;
        check("t1_rdata_hold", cpu_rdata,        32'hDEAD_BEEF);
        check("t1_stall_post", 32'(cpu_stall),   32'd0);
        check("t1_ar_post",    32'(ARVALID),     32'd0);
        check("t1_buserr",     32'(bus_err),     32'd0);
        tick();

        // ---------------- T2: write, W handshake 2 cycles before AW ----------------
        for (int c = 0; c < 6; c++) begin
            cpu_write = 1'b1;
            cpu_addr  = 32'h0002_0008;
            cpu_wdata = 32'h1234_5678;
            cpu_wstrb = 4'b0011;
            WREADY    = (c == 1);
            AWREADY   = (c == 3);
            BVALID    = (c == 5);
            #2;
            check($sformatf("t2_stall_c%0d", c),   32'(cpu_stall), 32'(c < 5));
            check($sformatf("t2_awvalid_c%0d", c), 32'(AWVALID),   32'(c >= 1 && c <= 3));
            check($sformatf("t2_wvalid_c%0d", c),  32'(WVALID),    32'(c == 1));
            check($sformatf("t2_wlast_c%0d", c),   32'(WLAST),     32'(c == 1));
            check($sformatf("t2_bready_c%0d", c),  32'(BREADY),    32'(c >= 4));
            check($sformatf("t2_arvalid_c%0d", c), 32'(ARVALID),   32'd0);
            if (c == 1) begin
                check("t2_wdata", WDATA,         32'h1234_5678);
                check("t2_wstrb", 32'(WSTRB),    32'h3);
            end
            if (c == 3) begin
                check("t2_awaddr",  AWADDR,       32'h0002_0008);
                check("t2_awid",    32'(AWID),    32'd1);
                check("t2_awsize",  32'(AWSIZE),  32'd2);
                check("t2_awburst", 32'(AWBURST), 32'd1);
                check("t2_awlen",   32'(AWLEN),   32'd0);
            end
            tick();
        end
        cpu_write = 1'b0;
        slave_idle();
        #2;
        check("t2_stall_post", 32'(cpu_stall), 32'd0);
        check("t2_buserr",     32'(bus_err),   32'd0);
        tick();

        // ---------------- T3: write with SLVERR, then OKAY read ----------------
        for (int c = 0; c < 3; c++) begin
            cpu_write = 1'b1;
            cpu_addr  = 32'h0000_0010;
            cpu_wdata = 32'h0BAD_0BAD;
            cpu_wstrb = 4'b1111;
            AWREADY   = (c == 1);
            WREADY    = (c == 1);
            BVALID    = (c == 2);
            BRESP     = RESP_SLVERR;
            #2;
            check($sformatf("t3w_stall_c%0d", c),   32'(cpu_stall), 32'(c < 2));
            check($sformatf("t3w_awvalid_c%0d", c), 32'(AWVALID),   32'(c == 1));
            check($sformatf("t3w_wvalid_c%0d", c),  32'(WVALID),    32'(c == 1));
            tick();
        end
        cpu_write = 1'b0;
        slave_idle();
        #2;
        check("t3_buserr_set", 32'(bus_err), 32'd1);
        tick();
        for (int c = 0; c < 3; c++) begin
            cpu_read = 1'b1;
            cpu_addr = 32'h0000_0020;
            ARREADY  = (c == 1);
            RVALID   = (c == 2);
            RDATA    = 32'hCAFE_F00D;
            #2;
            check($sformatf("t3r_stall_c%0d", c), 32'(cpu_stall), 32'(c < 2));
            check($sformatf("t3r_buserr_c%0d", c), 32'(bus_err), 32'd1);
            tick();
        end
        cpu_read = 1'b0;
        slave_idle();
        #2;
        check("t3_rdata",       cpu_rdata,     32'hCAFE_F00D);
        check("t3_buserr_hold", 32'(bus_err),  32'd1);
        tick();

        // ---------------- T4: read and write together -> write only ----------------
        for (int c = 0; c < 4; c++) begin
            cpu_read  = (c < 3);
            cpu_write = (c < 3);
            cpu_addr  = 32'h0000_0040;
            cpu_wdata = 32'h5555_AAAA;
            cpu_wstrb = 4'b1000;
            AWREADY   = (c == 1);
            WREADY    = (c == 1);
            BVALID    = (c == 2);
            #2;
            check($sformatf("t4_arvalid_c%0d", c), 32'(ARVALID), 32'd0);
            check($sformatf("t4_awvalid_c%0d", c), 32'(AWVALID), 32'(c == 1));
            check($sformatf("t4_wvalid_c%0d", c),  32'(WVALID),  32'(c == 1));
            check($sformatf("t4_bready_c%0d", c),  32'(BREADY),  32'(c == 2));
            tick();
        end
        slave_idle();

        // ---------------- T5: reset while ARVALID=1, ARREADY=0 ----------------
        cpu_read = 1'b1;
        cpu_addr = 32'h0000_0080;
        #2;
        check("t5_stall_c0", 32'(cpu_stall), 32'd1);
        tick();
        #2;
        check("t5_arvalid_pre", 32'(ARVALID), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_arvalid_rst", 32'(ARVALID),   32'd0);
        check("t5_rready_rst",  32'(RREADY),    32'd0);
        check("t5_stall_rst",   32'(cpu_stall), 32'd1);
        check("t5_rdata_rst",   cpu_rdata,      32'd0);
        check("t5_buserr_rst",  32'(bus_err),   32'd0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cpu_read = 1'b1;
            cpu_addr = 32'h0000_0084;
            ARREADY  = (c == 1);
            RVALID   = (c == 2);
            RDATA    = 32'h7777_0001;
            #2;
            check($sformatf("t5_stall_c%0d", c),   32'(cpu_stall), 32'(c < 2));
            check($sformatf("t5_arvalid_c%0d", c), 32'(ARVALID),   32'(c == 1));
            if (c == 1) check("t5_araddr", ARADDR, 32'h0000_0084);
            if (c == 2) check("t5_rdata",  cpu_rdata, 32'h7777_0001);
            tick();
        end
        cpu_read = 1'b0;
        slave_idle();
        tick();

        // ---------------- T6: two back-to-back zero-wait reads ----------------
        for (int c = 0; c < 7; c++) begin
            cpu_read = (c < 6);
            cpu_addr = (c < 3) ? 32'h0000_1000 : 32'h0000_2000;
            ARREADY  = (c == 1 || c == 4);
            RVALID   = (c == 2 || c == 5);
            RDATA    = (c < 3) ? 32'hA1A1_A1A1 : 32'hB2B2_B2B2;
            #2;
            check($sformatf("t6_arvalid_c%0d", c), 32'(ARVALID),   32'(c == 1 || c == 4));
            check($sformatf("t6_stall_c%0d", c),   32'(cpu_stall), 32'(c != 2 && c != 5 && c != 6));
            if (c == 1) check("t6_araddr1", ARADDR, 32'h0000_1000);
            if (c == 4) check("t6_araddr2", ARADDR, 32'h0000_2000);
            if (c == 2) check("t6_rdata1", cpu_rdata, 32'hA1A1_A1A1);
            if (c == 5) check("t6_rdata2", cpu_rdata, 32'hB2B2_B2B2);
            if (c == 6) check("t6_rdata_hold", cpu_rdata, 32'hB2B2_B2B2);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
